gfau_modexp_ctrl: RTL and testbench
===================================

# gfau_modexp_ctrl

Initiator-side controller for the GFAU operation handshake. It computes base^exp mod prime by left-to-right square-and-multiply, issuing one GFAU multiply per step and waiting for the GFAU completion strobe. It sits between a host (key/point logic) and one GFAU instance, and is the control end of the GFAU `operation_select` / `done_from_control` / `done_to_control` interface.

## Interface
- SIZE, 32, operand/result width (matches GFAU)
- EXP_W, 8, exponent width
- TIMEOUT, 1023, max cycles to wait for GFAU done before error

- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  host request, sampled in IDLE only
- i_base  in  SIZE  base, latched on accept
- i_exp  in  EXP_W  exponent, latched on accept
- i_prime  in  SIZE  modulus, latched on accept
- o_busy  out  1  high from accept until o_done
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_done: bad operands or GFAU timeout
- o_result  out  SIZE  result, held until next accept
- o_in_0, o_in_1  out  SIZE  GFAU operands
- o_prime  out  SIZE  GFAU modulus
- o_op_sel  out  2  GFAU operation (always MUL here)
- o_start  out  1  to GFAU done_from_control
- i_result  in  SIZE  from GFAU result
- i_done  in  1  from GFAU done_to_control

## Operation
- States: IDLE, CHECK, SQUARE, MULT, NEXT, FINISH.
- IDLE: i_start=1 latches base/exp/prime, acc<=1, bit index k<=EXP_W-1, -> CHECK. i_start outside IDLE is ignored.
- CHECK: prime<2 or base>=prime -> err=1, result=0, FINISH, no GFAU traffic. exp==0 -> result=1, FINISH, no GFAU traffic. Else -> SQUARE.
- SQUARE: issue acc*acc; on i_done acc<=i_result; exp[k]=1 -> MULT else -> NEXT.
- MULT: issue acc*base; on i_done acc<=i_result -> NEXT.
- NEXT: k==0 -> result<=acc, FINISH; else k<=k-1, -> SQUARE.
- FINISH: o_done=1 one cycle, -> IDLE.
- All EXP_W bits are processed (no leading-zero skip): GFAU transaction count = EXP_W + popcount(exp), deterministic.
- Issue rule: o_op_sel=2, o_start=1, o_in_0/o_in_1/o_prime stable while waiting; o_start drops the cycle after i_done is sampled high. Result captured only in the cycle i_done=1. i_done while not issuing is ignored.
- Timeout: per-transaction wait counter; reaching TIMEOUT without i_done -> o_start low, err=1, result=0, FINISH.

## Timing
- Reset (async, any state): state=IDLE, o_busy=0, o_done=0, o_err=0, o_result=0, o_start=0, o_op_sel=0, o_in_0=o_in_1=o_prime=0, counters 0. Reset mid-transaction abandons it; o_start falls immediately.
- Accept cycle -> o_busy high next edge. CHECK takes 1 cycle.
- Each transaction: o_start rises the edge after entering SQUARE/MULT; total = GFAU latency + 1 cycle. NEXT is 1 cycle.
- Early-exit paths (error/exp=0): o_done 2 cycles after accept.
- o_done and o_busy falling coincide; new i_start accepted the cycle after o_done.
- i_done asserted in the same cycle o_start first rises is valid and accepted.

## Structure
- gfau_pkg: op encodings GF_ADD=0, GF_SUB=1, GF_MUL=2, GF_DIV=3; controller state enum; shared by GFAU and this block.
- One sub-module, gfau_req_port: owns o_start/operand registers, i_done capture and the timeout counter; exposes issue/complete/timeout to the FSM.

## Test plan
- SIZE=32, EXP_W=8, base=3, exp=5, prime=7 with GFAU model of 3-cycle latency -> o_result=5, o_err=0, exactly 10 o_start transactions.
- base=2, exp=10, prime=97 -> o_result=54; base=86, exp=53, prime=97 -> matches bench reference model.
- exp=0, base=5, prime=7 -> o_result=1, o_done 2 cycles after accept, no o_start.
- base=100, prime=97 (and prime=1) -> o_err=1, o_result=0, no o_start.
- GFAU model withholds i_done -> o_err=1 after TIMEOUT cycles, o_start low; then normal request succeeds.
- i_rst_n pulsed low mid-MULT -> all outputs reset asynchronously; i_start during busy ignored; back-to-back requests give correct results.

Source files
------------

// File: rtl/gfau_pkg.sv
// Shared GFAU definitions: operation encodings and the modexp controller state set.
package gfau_pkg;

    typedef enum logic [1:0] {
        GF_ADD = 2'd0,
        GF_SUB = 2'd1,
        GF_MUL = 2'd2,
        GF_DIV = 2'd3
    } gf_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SQUARE,
        ST_MULT,
        ST_NEXT,
        ST_FINISH
    } ctrl_state_e;

endpackage

// File: rtl/gfau_modexp_ctrl_if.sv
// Host request/response and GFAU operation handshake seen by the modexp controller.
interface gfau_modexp_ctrl_if #(
    parameter int SIZE  = 32,
    parameter int EXP_W = 8
);
    logic             i_start;
    logic [SIZE-1:0]  i_base;
    logic [EXP_W-1:0] i_exp;
    logic [SIZE-1:0]  i_prime;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic [SIZE-1:0]  o_result;
    logic [SIZE-1:0]  o_in_0;
    logic [SIZE-1:0]  o_in_1;
    logic [SIZE-1:0]  o_prime;
    logic [1:0]       o_op_sel;
    logic             o_start;
    logic [SIZE-1:0]  i_result;
    logic             i_done;

    modport master (
        input  i_start, i_base, i_exp, i_prime, i_result, i_done,
        output o_busy, o_done, o_err, o_result, o_in_0, o_in_1, o_prime, o_op_sel, o_start
    );

    modport slave (
        output i_start, i_base, i_exp, i_prime, i_result, i_done,
        input  o_busy, o_done, o_err, o_result, o_in_0, o_in_1, o_prime, o_op_sel, o_start
    );
endinterface

// File: rtl/gfau_req_port.sv
// GFAU request port: holds o_start and operands for one multiply until done or timeout.
module gfau_req_port
    import gfau_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            issue,
    input  logic [SIZE-1:0] in_0,
    input  logic [SIZE-1:0] in_1,
    input  logic [SIZE-1:0] prime,
    output logic            pending,
    output logic            complete,
    output logic            timeout,
    output logic            o_start,
    output logic [SIZE-1:0] o_in_0,
    output logic [SIZE-1:0] o_in_1,
    output logic [SIZE-1:0] o_prime,
    output logic [1:0]      o_op_sel,
    input  logic            i_done
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic             start_reg;
    logic [SIZE-1:0]  in_0_reg;
    logic [SIZE-1:0]  in_1_reg;
    logic [SIZE-1:0]  prime_reg;
    gf_op_e           op_sel_reg;
    logic [CNT_W-1:0] wait_cnt_reg;

    // i_done only counts while a request is outstanding; stray strobes are dropped.
    assign complete = start_reg & i_done;
    assign timeout  = start_reg & ~i_done & (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
    assign pending  = start_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            start_reg    <= 1'b0;
            in_0_reg     <= '0;
            in_1_reg     <= '0;
            prime_reg    <= '0;
            op_sel_reg   <= GF_ADD;
            wait_cnt_reg <= '0;
        end else if (issue) begin
            start_reg    <= 1'b1;
            in_0_reg     <= in_0;
            in_1_reg     <= in_1;
            prime_reg    <= prime;
            op_sel_reg   <= GF_MUL;
            wait_cnt_reg <= '0;
        end else if (complete || timeout) begin
            start_reg    <= 1'b0;
            wait_cnt_reg <= '0;
        end else if (start_reg) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    assign o_start  = start_reg;
    assign o_in_0   = in_0_reg;
    assign o_in_1   = in_1_reg;
    assign o_prime  = prime_reg;
    assign o_op_sel = op_sel_reg;

endmodule

// File: rtl/gfau_modexp_ctrl.sv
// Modular exponentiation controller: left-to-right square-and-multiply over all exponent bits,
// one GFAU multiply per step.
module gfau_modexp_ctrl
    import gfau_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int EXP_W   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst_n,
    gfau_modexp_ctrl_if.master bus
);
    localparam int K_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    ctrl_state_e      state_reg,  state_next;
    logic [SIZE-1:0]  acc_reg,    acc_next;
    logic [SIZE-1:0]  base_reg,   base_next;
    logic [SIZE-1:0]  prime_reg,  prime_next;
    logic [EXP_W-1:0] exp_reg,    exp_next;
    logic [K_W-1:0]   k_reg,      k_next;
    logic [SIZE-1:0]  result_reg, result_next;
    logic             err_reg,    err_next;

    logic            issue;
    logic [SIZE-1:0] op_b;
    logic            pending;
    logic            complete;
    logic            timeout;

    gfau_req_port #(
        .SIZE    (SIZE),
        .TIMEOUT (TIMEOUT)
    ) u_req_port (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .issue    (issue),
        .in_0     (acc_reg),
        .in_1     (op_b),
        .prime    (prime_reg),
        .pending  (pending),
        .complete (complete),
        .timeout  (timeout),
        .o_start  (bus.o_start),
        .o_in_0   (bus.o_in_0),
        .o_in_1   (bus.o_in_1),
        .o_prime  (bus.o_prime),
        .o_op_sel (bus.o_op_sel),
        .i_done   (bus.i_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            base_reg   <= '0;
            prime_reg  <= '0;
            exp_reg    <= '0;
            k_reg      <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            base_reg   <= base_next;
            prime_reg  <= prime_next;
            exp_reg    <= exp_next;
            k_reg      <= k_next;
            result_reg <= result_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        base_next   = base_reg;
        prime_next  = prime_reg;
        exp_next    = exp_reg;
        k_next      = k_reg;
        result_next = result_reg;
        err_next    = err_reg;
        issue       = 1'b0;
        op_b        = acc_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.i_start) begin
                    base_next  = bus.i_base;
                    exp_next   = bus.i_exp;
                    prime_next = bus.i_prime;
                    acc_next   = SIZE'(1);
                    k_next     = K_W'(EXP_W - 1);
                    err_next   = 1'b0;
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (prime_reg < SIZE'(2) || base_reg >= prime_reg) begin
                    err_next    = 1'b1;
                    result_next = '0;
                    state_next  = ST_FINISH;
                end else if (exp_reg == '0) begin
                    result_next = SIZE'(1);
                    state_next  = ST_FINISH;
                end else begin
                    state_next = ST_SQUARE;
                end
            end
            ST_SQUARE, ST_MULT: begin
                // Issue once on entry; the port holds operands until done or timeout.
                issue = ~pending;
                op_b  = (state_reg == ST_MULT) ? base_reg : acc_reg;
                if (complete) begin
                    acc_next = bus.i_result;
                    if (state_reg == ST_SQUARE && exp_reg[k_reg])
                        state_next = ST_MULT;
                    else
                        state_next = ST_NEXT;
                end else if (timeout) begin
                    err_next    = 1'b1;
                    result_next = '0;
                    state_next  = ST_FINISH;
                end
            end
            ST_NEXT: begin
                if (k_reg == '0) begin
                    result_next = acc_reg;
                    state_next  = ST_FINISH;
                end else begin
                    k_next     = k_reg - 1'b1;
                    state_next = ST_SQUARE;
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign bus.o_busy   = (state_reg != ST_IDLE);
    assign bus.o_done   = (state_reg == ST_FINISH);
    assign bus.o_err    = err_reg;
    assign bus.o_result = result_reg;

endmodule

// File: tb/tb_gfau_modexp_ctrl.sv
// Bench for gfau_modexp_ctrl: GFAU multiply model with programmable latency plus a
// repeated-multiplication reference for base^exp mod prime.
module tb_gfau_modexp_ctrl;
    localparam int SIZE    = 32;
    localparam int EXP_W   = 8;
    localparam int TIMEOUT = 1023;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gfau_modexp_ctrl_if #(.SIZE(SIZE), .EXP_W(EXP_W)) bus ();

    gfau_modexp_ctrl #(
        .SIZE    (SIZE),
        .EXP_W   (EXP_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    int gf_lat   = 1;
    bit gf_hold  = 1'b0;
    bit gf_noise = 1'b0;
    int txn      = 0;
    int gf_cnt   = 0;
    bit gf_prev  = 1'b0;

    task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Behavioural reference: plain repeated multiplication, no bit scanning.
    task automatic ref_model(input longint unsigned b, input longint unsigned e, input longint unsigned p,
                             output longint unsigned r, output bit err);
        if (p < 2 || b >= p) begin
            err = 1'b1;
            r   = 0;
        end else begin
            err = 1'b0;
            r   = 1;
            for (longint unsigned i = 0; i < e; i++) r = (r * b) % p;
        end
    endtask

    // GFAU model: answers the L-th cycle o_start is seen high; optional stray i_done while idle.
    initial begin
        longint unsigned a0, a1, pm;
        bus.i_done   = 1'b0;
        bus.i_result = '0;
        forever begin
            @(negedge clk);
            if (bus.o_start) begin
                if (!gf_prev) txn++;
                gf_cnt++;
                if (!gf_hold && gf_cnt == gf_lat) begin
                    a0 = bus.o_in_0;
                    a1 = bus.o_in_1;
                    pm = bus.o_prime;
                    bus.i_done   = 1'b1;
                    bus.i_result = SIZE'((a0 * a1) % pm);
                end else begin
                    bus.i_done   = 1'b0;
                    bus.i_result = $urandom;
                end
            end else begin
                gf_cnt       = 0;
                bus.i_done   = gf_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.i_result = $urandom;
            end
            gf_prev = bus.o_start;
        end
    end

    task automatic run_req(input logic [SIZE-1:0] b, input logic [EXP_W-1:0] e, input logic [SIZE-1:0] p,
                           input int lat, input bit noise, input bit hold, input bit poke);
        longint unsigned r_exp;
        bit              err_exp;
        int              cyc;
        int              t0;
        bit              seen;
        int              exp_txn;
        int              exp_cyc;
        ref_model(b, e, p, r_exp, err_exp);
        if (hold && !err_exp && e != 0) begin
            err_exp = 1'b1;
            r_exp   = 0;
            exp_txn = 1;
            exp_cyc = TIMEOUT + 3;
        end else if (!err_exp && e != 0) begin
            exp_txn = EXP_W + $countones(e);
            exp_cyc = 2 + EXP_W * (lat + 2) + $countones(e) * (lat + 1);
        end else begin
            exp_txn = 0;
            exp_cyc = 2;
        end
        gf_lat   = lat;
        gf_noise = noise;
        gf_hold  = hold;
        @(negedge clk);
        check_eq("idle_busy", bus.o_busy, 0);
        check_eq("idle_done", bus.o_done, 0);
        bus.i_start = 1'b1;
        bus.i_base  = b;
        bus.i_exp   = e;
        bus.i_prime = p;
        t0   = txn;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 3000 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.i_start = 1'b0;
                check_eq("busy_after_accept", bus.o_busy, 1);
            end
            if (poke && cyc == 10) begin
                bus.i_start = 1'b1;
                bus.i_base  = $urandom;
                bus.i_exp   = $urandom;
                bus.i_prime = $urandom;
            end
            if (poke && cyc == 11) bus.i_start = 1'b0;
            seen = bus.o_done;
        end
        if (!seen) begin
            check_eq("done_wait", 0, 1);
        end else begin
            check_eq("result", bus.o_result, r_exp);
            check_eq("err", bus.o_err, err_exp);
            check_eq("txn_count", longint'(txn - t0), longint'(exp_txn));
            check_eq("done_cycle", longint'(cyc), longint'(exp_cyc));
            check_eq("busy_at_done", bus.o_busy, 1);
            check_eq("start_low_at_done", bus.o_start, 0);
        end
        $display("req base=%0d exp=%0d prime=%0d lat=%0d hold=%0d result=%0d err=%0d txns=%0d cycles=%0d",
                 b, e, p, lat, hold, bus.o_result, bus.o_err, txn - t0, cyc);
        gf_hold = 1'b0;
    endtask

    task automatic reset_mid_mult();
        int t0;
        int cyc;
        gf_lat   = 3;
        gf_noise = 1'b0;
        gf_hold  = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_base  = 3;
        bus.i_exp   = 8'hFF;
        bus.i_prime = 7;
        t0  = txn;
        cyc = 0;
        while (cyc < 200 && !((txn - t0) == 2 && bus.o_start)) begin
            @(negedge clk);
            cyc++;
            bus.i_start = 1'b0;
        end
        check_eq("reached_mult", longint'(txn - t0), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_start", bus.o_start, 0);
        check_eq("rst_busy", bus.o_busy, 0);
        check_eq("rst_done", bus.o_done, 0);
        check_eq("rst_err", bus.o_err, 0);
        check_eq("rst_result", bus.o_result, 0);
        check_eq("rst_in_0", bus.o_in_0, 0);
        check_eq("rst_in_1", bus.o_in_1, 0);
        check_eq("rst_prime", bus.o_prime, 0);
        check_eq("rst_op_sel", bus.o_op_sel, 0);
        $display("req reset asserted mid-MULT after %0d cycles", cyc);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [SIZE-1:0]  rb, rp;
        logic [EXP_W-1:0] re;
        bus.i_start = 1'b0;
        bus.i_base  = '0;
        bus.i_exp   = '0;
        bus.i_prime = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", bus.o_busy, 0);
        check_eq("reset_done", bus.o_done, 0);
        check_eq("reset_err", bus.o_err, 0);
        check_eq("reset_result", bus.o_result, 0);
        check_eq("reset_start", bus.o_start, 0);
        check_eq("reset_op_sel", bus.o_op_sel, 0);
        check_eq("reset_in_0", bus.o_in_0, 0);
        rst_n = 1'b1;

        run_req(3, 5, 7, 3, 0, 0, 0);
        check_eq("op_sel_mul", bus.o_op_sel, 2);
        run_req(2, 10, 97, 2, 0, 0, 0);
        check_eq("fixed_2_10_97", bus.o_result, 54);
        run_req(86, 53, 97, 1, 1, 0, 1);
        run_req(5, 0, 7, 2, 0, 0, 0);
        run_req(100, 5, 97, 2, 0, 0, 0);
        run_req(5, 3, 1, 2, 0, 0, 0);
        run_req(3, 5, 7, 1, 0, 1, 0);
        run_req(2, 10, 97, 1, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            rp = $urandom_range(2, 100000);
            rb = (i % 5 == 4) ? rp + $urandom_range(0, 10) : $urandom_range(0, int'(rp) - 1);
            re = (i % 6 == 5) ? '0 : EXP_W'($urandom);
            run_req(rb, re, rp, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 0,
                    (re != 0 && rb < rp));
        end

        reset_mid_mult();
        run_req(86, 53, 97, 1, 0, 0, 0);
        run_req(7, 200, 1009, 2, 1, 0, 0);
        run_req(0, 9, 13, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
